// File: rtl/stream_demux_1to2.sv
// rtl/stream_demux_1to2.sv - 1-to-2 stream demultiplexer with per-channel FIFOs and accept counters
//
// stream_demux_1to2: routes each accepted input word to channel 0 or 1 by in_sel.
// Each channel buffers up to DEPTH words and counts its accepts (saturating at 255).
//   clk, reset                        - clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_sel  - input stream, in_sel picks the channel
//   out0_valid/out0_ready/out0_data   - channel 0 output stream
//   out1_valid/out1_ready/out1_data   - channel 1 output stream
//   cnt0, cnt1                        - words accepted per channel since reset
//
// stream_demux_fifo: per-channel circular buffer.
//   push/push_data                    - write one word (caller guarantees not full)
//   pop                               - advance head (ignored when empty)
//   full/valid/head_data              - status and head entry (zero when empty)

module stream_demux_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign valid     = (count != '0);
    assign head_data = valid ? mem[rd_ptr] : '0;
    // Popping an empty buffer is a no-op so the count can never underflow.
    assign do_pop    = pop && valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module stream_demux_1to2 #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // Readiness depends only on the selected channel's fullness; a pop in the
    // same cycle does not free a slot for the incoming word.
    assign in_ready = in_sel ? !full1 : !full0;
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready &&  in_sel;

    stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .valid     (out0_valid),
        .head_data (out0_data)
    );

    stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .valid     (out1_valid),
        .head_data (out1_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0 && cnt0 != 8'hFF) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (push1 && cnt1 != 8'hFF) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb/tb_stream_demux_1to2.sv - directed self-checking bench for stream_demux_1to2

module tb_stream_demux_1to2;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [3:0] out1_data;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_demux_1to2 #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_data = 4'h0; in_sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic sel, input logic [3:0] data);
        in_valid = 1'b1; in_sel = sel; in_data = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        #0;
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL %s out0_valid: got %b expected 0", tag, out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL %s out1_valid: got %b expected 0", tag, out1_valid); end
        checks++; if (out0_data !== 4'h0) begin errors++; $display("FAIL %s out0_data: got %h expected 0", tag, out0_data); end
        checks++; if (out1_data !== 4'h0) begin errors++; $display("FAIL %s out1_data: got %h expected 0", tag, out1_data); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL %s cnt0: got %0d expected 0", tag, cnt0); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL %s cnt1: got %0d expected 0", tag, cnt1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b expected 1", tag, in_ready); end
    endtask

    task automatic test_reset();
        // Traffic offered during reset must be ignored.
        reset = 1'b1; in_valid = 1'b1; in_data = 4'hE; in_sel = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        idle();
        check_reset_values("reset");
    endtask

    task automatic test_routing();
        apply_reset();
        push(1'b0, 4'hA);
        checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL route_latency out0_valid: got %b expected 1", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_other out1_valid: got %b expected 0", out1_valid); end
        push(1'b1, 4'h5);
        checks++; if (out0_data !== 4'hA) begin errors++; $display("FAIL route out0_data: got %h expected a", out0_data); end
        checks++; if (out1_data !== 4'h5) begin errors++; $display("FAIL route out1_data: got %h expected 5", out1_data); end
        checks++; if ({out0_valid, out1_valid} !== 2'b11) begin errors++; $display("FAIL route valids: got %b expected 11", {out0_valid, out1_valid}); end
        checks++; if (cnt0 !== 8'd1) begin errors++; $display("FAIL route cnt0: got %0d expected 1", cnt0); end
        checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL route cnt1: got %0d expected 1", cnt1); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push(1'b0, 4'h3);
        push(1'b0, 4'h7);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full in_ready sel0: got %b expected 0", in_ready); end
        in_sel = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full in_ready sel1: got %b expected 1", in_ready); end
        in_sel = 1'b0;
        // Pop offered together with the blocked push: no pass-through.
        out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full in_ready with pop: got %b expected 0", in_ready); end
        step();
        in_valid = 1'b0; out0_ready = 1'b0;
        checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL full cnt0: got %0d expected 2", cnt0); end
        checks++; if (out0_data !== 4'h7) begin errors++; $display("FAIL full out0_data: got %h expected 7", out0_data); end
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL full third_word_stored out0_valid: got %b expected 0", out0_valid); end
    endtask

    task automatic test_push_pop_and_drain();
        apply_reset();
        push(1'b0, 4'h2);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h9; out0_ready = 1'b1;
        step();
        in_valid = 1'b0; out0_ready = 1'b0;
        checks++; if (out0_data !== 4'h9) begin errors++; $display("FAIL pushpop out0_data: got %h expected 9", out0_data); end
        checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL pushpop out0_valid: got %b expected 1", out0_valid); end
        // Occupancy must still be one: one more word fills it exactly.
        push(1'b0, 4'hB);
        in_sel = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pushpop count in_ready: got %b expected 0", in_ready); end
        out0_ready = 1'b1;
        step();
        checks++; if (out0_data !== 4'hB) begin errors++; $display("FAIL drain second out0_data: got %h expected b", out0_data); end
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL drain idle%0d out0_valid: got %b expected 0", i, out0_valid); end
            checks++; if (out0_data !== 4'h0) begin errors++; $display("FAIL drain idle%0d out0_data: got %h expected 0", i, out0_data); end
        end
        out0_ready = 1'b0;
        push(1'b0, 4'hC);
        checks++; if (out0_data !== 4'hC) begin errors++; $display("FAIL drain no_underflow out0_data: got %h expected c", out0_data); end
        checks++; if (cnt0 !== 8'd4) begin errors++; $display("FAIL drain cnt0: got %0d expected 4", cnt0); end
    endtask

    task automatic test_dual_pop();
        apply_reset();
        push(1'b0, 4'h1);
        push(1'b0, 4'h2);
        push(1'b1, 4'h4);
        push(1'b1, 4'h8);
        out0_ready = 1'b1; out1_ready = 1'b1;
        step();
        out0_ready = 1'b0; out1_ready = 1'b0;
        checks++; if (out0_data !== 4'h2) begin errors++; $display("FAIL dualpop out0_data: got %h expected 2", out0_data); end
        checks++; if (out1_data !== 4'h8) begin errors++; $display("FAIL dualpop out1_data: got %h expected 8", out1_data); end
    endtask

    task automatic test_saturation();
        apply_reset();
        in_valid = 1'b1; in_sel = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 254; i++) step();
        checks++; if (cnt1 !== 8'd254) begin errors++; $display("FAIL sat cnt1_254: got %0d expected 254", cnt1); end
        for (int i = 0; i < 6; i++) step();
        idle();
        checks++; if (cnt1 !== 8'd255) begin errors++; $display("FAIL sat cnt1: got %0d expected 255", cnt1); end
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL sat cnt0: got %0d expected 0", cnt0); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        push(1'b0, 4'h6);
        push(1'b0, 4'h7);
        push(1'b1, 4'hD);
        push(1'b1, 4'hE);
        in_sel = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset full1 in_ready: got %b expected 0", in_ready); end
        reset = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
        out0_ready = 1'b1; out1_ready = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check_reset_values("midreset");
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_routing();
        test_backpressure();
        test_push_pop_and_drain();
        test_dual_pop();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width of input and both output channels.
REQ-002 SHALL have parameter DEPTH, default 2: entries per output-channel FIFO (power of two, >=2).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: producer offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH: payload.
REQ-008 SHALL have port in_sel  input  1: destination; 0 -> channel 0, 1 -> channel 1.
REQ-009 SHALL have port out0_valid  output  1: channel 0 head entry present.
REQ-010 SHALL have port out0_ready  input  1: channel 0 consumer takes head.
REQ-011 SHALL have port out0_data  output  WIDTH: channel 0 head entry.
REQ-012 SHALL have ports out1_valid / out1_ready / out1_data with the same directions, widths and meanings for channel 1.
REQ-013 SHALL have ports cnt0, cnt1  output  8: words accepted into channel 0 / channel 1 since reset.

Function
REQ-014 SHALL define accept as in_valid & in_ready at a rising edge; pop on channel k as outk_valid & outk_ready.
REQ-015 SHALL drive in_ready = NOT full(channel selected by in_sel), combinationally; in_ready independent of in_valid and of any same-cycle pop (no pass-through when full).
REQ-016 SHALL write an accepted word only into the FIFO of the channel selected by in_sel; the other FIFO is unchanged.
REQ-017 SHALL drive outk_valid = 1 iff channel k FIFO count > 0.
REQ-018 SHALL drive outk_data = oldest stored entry of channel k when outk_valid=1, and all-zero when empty.
REQ-019 SHALL have latency one cycle: word accepted at edge N appears on outk_data/outk_valid immediately after edge N if channel k was empty.
REQ-020 SHALL preserve order within each channel; no ordering relation between channels.
REQ-021 SHALL, on simultaneous push and pop of the same channel, keep count unchanged, advance head and write tail in the same edge.
REQ-022 SHALL ignore outk_ready while outk_valid=0 (no underflow, count stays 0).
REQ-023 SHALL use wrap-around read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits per channel.
REQ-024 SHALL increment cntk by 1 on each accept into channel k, saturating at 255 (holds 255).
REQ-025 SHALL permit both channels to pop in the same cycle independently.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, clear both FIFO counts and pointers, cnt0, cnt1 to 0, regardless of in-flight traffic.
REQ-027 SHALL after reset present out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0, in_ready=1.
REQ-028 SHALL ignore in_valid and outk_ready on a cycle where reset=1 (no accept, no pop, counters unchanged from 0).

Verification
REQ-029 SHALL verify routing: after reset, push 4'hA sel=0 then 4'h5 sel=1, readies low -> out0_data=A, out1_data=5, both valid, cnt0=1, cnt1=1.
REQ-030 SHALL verify full/backpressure: push 3,7 sel=0 with out0_ready=0 -> in_ready=0 while sel=0, in_ready=1 when sel switched to 1; third sel=0 word not stored.
REQ-031 SHALL verify simultaneous push/pop: channel 0 holds one word 2, push 9 sel=0 with out0_ready=1 -> next cycle out0_data=9, count stays 1.
REQ-032 SHALL verify drain/underflow: pop both entries then hold out0_ready=1 three more cycles -> out0_valid=0, out0_data=0, no state change.
REQ-033 SHALL verify counter saturation: 260 accepts to channel 1 with out1_ready=1 -> cnt1=255, cnt0=0.
REQ-034 SHALL verify mid-operation reset: both FIFOs full, assert reset one cycle with in_valid=1 -> all outputs at REQ-027 values next cycle.
